// File: rtl/dieu_khien_che_do.sv
// Mode / set-sequence controller for the century clock: button edges -> mode, step pulses, blink.
// Define AUTO_REPEAT_EN to enable the hold counter and auto-repeat of held step buttons.
module dieu_khien_che_do #(
    parameter int TIMEOUT    = 10,
    parameter int HOLD_DELAY = 2
) (
    input  logic       clk_1Hz,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [2:0] mode,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       blink,
    output logic       run_en
);

    // state     | meaning
    // RUN       | normal timekeeping, run_en = 1, steps ignored
    // SET_GIO   | editing hours
    // SET_PHUT  | editing minutes
    // SET_GIAY  | editing seconds
    // SET_NGAY  | editing day
    // SET_THANG | editing month
    // SET_NAM   | editing year
    // BAD       | unused code, falls back to RUN on the next edge
    typedef enum logic [2:0] {
        RUN       = 3'b000,
        SET_GIO   = 3'b001,
        SET_PHUT  = 3'b010,
        SET_GIAY  = 3'b011,
        SET_NGAY  = 3'b100,
        SET_THANG = 3'b101,
        SET_NAM   = 3'b110,
        BAD       = 3'b111
    } mode_t;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("TIMEOUT out of range 2..255");
    end
    if (HOLD_DELAY < 1 || HOLD_DELAY > 15) begin : g_bad_hold
        $error("HOLD_DELAY out of range 1..15");
    end

    mode_t      state_q, state_d;
    logic       prev_m, prev_u, prev_d;
    logic [7:0] idle_q, idle_d, idle_inc;
    logic       press_m, press_u, press_d;
    logic       up_low, dn_low, activity, mode_chg, step_gate;
    logic       inc_d, dec_d, blink_q, blink_d;
`ifdef AUTO_REPEAT_EN
    logic [3:0] hold_q, hold_d;
    logic       rep;
`endif

    always_comb begin
        press_m  = prev_m & ~btn_mode;
        press_u  = prev_u & ~btn_up;
        press_d  = prev_d & ~btn_down;
        up_low   = ~btn_up;
        dn_low   = ~btn_down;
        activity = press_m | press_u | press_d | up_low | dn_low;
        idle_inc = idle_q + 8'd1;

        state_d = state_q;
        if (state_q == BAD)
            state_d = RUN;
        else if (press_m)
            state_d = (state_q == SET_NAM) ? RUN : mode_t'(state_q + 3'd1);
        else if (state_q != RUN && !activity && idle_inc == 8'(TIMEOUT))
            state_d = RUN;

        mode_chg = (state_d != state_q);
        idle_d   = (activity || mode_chg || state_q == RUN) ? 8'd0 : idle_inc;

        // mode press wins over steps; both step buttons low cancels each other
        step_gate = (state_q != RUN) && (state_q != BAD) && !press_m && !(up_low && dn_low);

`ifdef AUTO_REPEAT_EN
        hold_d = 4'd0;
        rep    = 1'b0;
        if (step_gate && (up_low ^ dn_low)) begin
            rep    = (hold_q == 4'(HOLD_DELAY));
            hold_d = rep ? hold_q : hold_q + 4'd1;
        end
        inc_d = step_gate && up_low && (press_u || rep);
        dec_d = step_gate && dn_low && (press_d || rep);
`else
        inc_d = step_gate && press_u;
        dec_d = step_gate && press_d;
`endif

        blink_d = (mode_chg || state_d == RUN) ? 1'b0 : ~blink_q;
    end

    always_ff @(posedge clk_1Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            prev_m    <= 1'b1;
            prev_u    <= 1'b1;
            prev_d    <= 1'b1;
            idle_q    <= 8'd0;
            inc_pulse <= 1'b0;
            dec_pulse <= 1'b0;
            blink_q   <= 1'b0;
            run_en    <= 1'b1;
`ifdef AUTO_REPEAT_EN
            hold_q    <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            prev_m    <= btn_mode;
            prev_u    <= btn_up;
            prev_d    <= btn_down;
            idle_q    <= idle_d;
            inc_pulse <= inc_d;
            dec_pulse <= dec_d;
            blink_q   <= blink_d;
            run_en    <= (state_d == RUN);
`ifdef AUTO_REPEAT_EN
            hold_q    <= hold_d;
`endif
        end
    end

    assign mode  = state_q;
    assign blink = blink_q;

endmodule

// File: tb/tb_dieu_khien_che_do.sv
// Scoreboard bench for dieu_khien_che_do: stimulus pushes per-cycle expectations, a negedge monitor checks them.
module tb_dieu_khien_che_do;

`ifdef AUTO_REPEAT_EN
    localparam logic AR = 1'b1;
`else
    localparam logic AR = 1'b0;
`endif

    logic       clk_1Hz = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode = 1'b1, btn_up = 1'b1, btn_down = 1'b1;
    logic [2:0] mode;
    logic       inc_pulse, dec_pulse, blink, run_en;

    dieu_khien_che_do #(.TIMEOUT(10), .HOLD_DELAY(2)) dut (
        .clk_1Hz  (clk_1Hz),
        .rst_n    (rst_n),
        .btn_mode (btn_mode),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .mode     (mode),
        .inc_pulse(inc_pulse),
        .dec_pulse(dec_pulse),
        .blink    (blink),
        .run_en   (run_en)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    typedef struct {
        string      tag;
        logic [2:0] m;
        logic       i;
        logic       d;
        logic       b;
        logic       r;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;

    always @(negedge clk_1Hz) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            n_total++;
            if ({mode, inc_pulse, dec_pulse, blink, run_en} ===
                {mon_e.m, mon_e.i, mon_e.d, mon_e.b, mon_e.r})
                n_pass++;
            else
                $display("FAIL %s: got mode=%b inc=%b dec=%b blink=%b run_en=%b, want mode=%b inc=%b dec=%b blink=%b run_en=%b",
                         mon_e.tag, mode, inc_pulse, dec_pulse, blink, run_en,
                         mon_e.m, mon_e.i, mon_e.d, mon_e.b, mon_e.r);
        end
    end

    task automatic push_exp(input logic [2:0] em, input logic ei, input logic ed,
                            input logic eb, input string tag);
        exp_t e;
        e.tag = tag;
        e.m   = em;
        e.i   = ei;
        e.d   = ed;
        e.b   = eb;
        e.r   = (em == 3'd0);
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs; the expectation is for outputs after the next rising edge.
    task automatic cyc(input logic r, input logic m, input logic u, input logic d,
                       input logic [2:0] em, input logic ei, input logic ed,
                       input logic eb, input string tag);
        @(negedge clk_1Hz);
        #1;
        rst_n    = r;
        btn_mode = m;
        btn_up   = u;
        btn_down = d;
        push_exp(em, ei, ed, eb, tag);
    endtask

    // Reset pulled low shortly after a rising edge, before the sampling point.
    task automatic rst_mid(input logic m, input logic u, input logic d, input string tag);
        @(negedge clk_1Hz);
        #1;
        btn_mode = m;
        btn_up   = u;
        btn_down = d;
        push_exp(3'd0, 1'b0, 1'b0, 1'b0, tag);
        @(posedge clk_1Hz);
        #2;
        rst_n = 1'b0;
    endtask

    initial begin
        cyc(0, 1, 1, 1, 3'd0, 0, 0, 0, "reset0");
        cyc(0, 1, 1, 1, 3'd0, 0, 0, 0, "reset1");

        // full mode walk, presses two cycles apart
        for (int i = 1; i <= 7; i++) begin
            cyc(1, 0, 1, 1, 3'(i % 7), 0, 0, 0, $sformatf("walk_press%0d", i));
            cyc(1, 1, 1, 1, 3'(i % 7), 0, 0, logic'((i % 7) != 0), $sformatf("walk_hold%0d", i));
        end

        cyc(1, 1, 0, 1, 3'd0, 0, 0, 0, "run_up_ignored");
        cyc(1, 1, 1, 1, 3'd0, 0, 0, 0, "run_up_release");

        // into SET_NGAY, then hold up for six cycles
        for (int i = 1; i <= 4; i++) begin
            cyc(1, 0, 1, 1, 3'(i), 0, 0, 0, $sformatf("to_ngay_press%0d", i));
            cyc(1, 1, 1, 1, 3'(i), 0, 0, 1, $sformatf("to_ngay_hold%0d", i));
        end
        cyc(1, 1, 0, 1, 3'd4, 1, 0, 0, "ngay_up_press");
        for (int j = 1; j <= 5; j++)
            cyc(1, 1, 0, 1, 3'd4, (j >= 2) ? AR : 1'b0, 0, logic'(j % 2), $sformatf("ngay_up_held%0d", j));
        cyc(1, 1, 1, 1, 3'd4, 0, 0, 0, "ngay_up_release");

        // SET_THANG: mode and down together -> SET_NAM, no dec
        cyc(1, 0, 1, 1, 3'd5, 0, 0, 0, "to_thang");
        cyc(1, 1, 1, 1, 3'd5, 0, 0, 1, "thang_idle");
        cyc(1, 0, 1, 0, 3'd6, 0, 0, 0, "thang_mode_down");

        // SET_NAM idle: back to RUN ten edges after the press
        for (int i = 1; i <= 9; i++)
            cyc(1, 1, 1, 1, 3'd6, 0, 0, logic'(i % 2), $sformatf("nam_idle%0d", i));
        cyc(1, 1, 1, 1, 3'd0, 0, 0, 0, "nam_timeout");
        cyc(1, 1, 1, 1, 3'd0, 0, 0, 0, "run_after_timeout");

        // SET_GIO: up and down together, then down released while up held
        cyc(1, 0, 1, 1, 3'd1, 0, 0, 0, "to_gio");
        cyc(1, 1, 1, 1, 3'd1, 0, 0, 1, "gio_idle");
        cyc(1, 1, 0, 0, 3'd1, 0, 0, 0, "gio_both_low");
        cyc(1, 1, 0, 1, 3'd1, 0, 0, 1, "gio_up_only0");
        cyc(1, 1, 0, 1, 3'd1, 0, 0, 0, "gio_up_only1");
        cyc(1, 1, 0, 1, 3'd1, AR, 0, 1, "gio_up_only2");
        cyc(1, 1, 1, 1, 3'd1, 0, 0, 0, "gio_up_release");
        cyc(1, 1, 1, 0, 3'd1, 0, 1, 1, "gio_down_press");
        cyc(1, 1, 1, 1, 3'd1, 0, 0, 0, "gio_down_release");

        // SET_PHUT with up held, reset arrives mid-cycle
        cyc(1, 0, 1, 1, 3'd2, 0, 0, 0, "to_phut");
        cyc(1, 1, 1, 1, 3'd2, 0, 0, 1, "phut_idle");
        cyc(1, 1, 0, 1, 3'd2, 1, 0, 0, "phut_up_press");
        rst_mid(1, 0, 1, "async_reset");
        cyc(0, 1, 0, 1, 3'd0, 0, 0, 0, "reset_held");
        cyc(1, 1, 0, 1, 3'd0, 0, 0, 0, "reset_release_up_low");
        cyc(1, 1, 1, 1, 3'd0, 0, 0, 0, "run_up_release2");
        cyc(1, 1, 0, 1, 3'd0, 0, 0, 0, "run_first_up");
        cyc(1, 1, 1, 1, 3'd0, 0, 0, 0, "run_first_up_release");
        cyc(1, 0, 1, 1, 3'd1, 0, 0, 0, "after_reset_mode");
        cyc(1, 1, 1, 1, 3'd1, 0, 0, 1, "after_reset_idle");

        for (int k = 0; k < 5 && sb.size() != 0; k++)
            @(negedge clk_1Hz);
        #1;
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d expectations left, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
